exc_flush_ctrl: RTL and testbench

//  Exception/ERET sequencer between the MEM stage and CP0. Samples the retiring MEM-stage

---
 rtl/exc_flush_ctrl_if.sv | 45 ++++
 rtl/exc_flush_ctrl.sv | 138 +++++++++++++
 tb/tb_exc_flush_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_flush_ctrl_if.sv
// Bundle between the exception sequencer, the MEM stage, CP0 and fetch.
// The slave modport is the sequencer's view; master is the surrounding pipeline.
interface exc_flush_ctrl_if;
  // MEM-stage retiring instruction
  logic        mem_valid_i;
  logic        mem_stall_i;
  logic [31:0] mem_pc_i;
  logic        mem_delayslot_i;
  logic [7:0]  mem_exc_i;
  logic [31:0] mem_badvaddr_i;
  // CP0 state
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  // Commit beat to CP0
  logic [31:0] excepttype_o;
  logic [31:0] exc_pc_o;
  logic [31:0] exc_badvaddr_o;
  logic        exc_delayslot_o;
  // Pipeline control
  logic        flush_o;
  logic        busy_o;
  // Redirect handshake to fetch
  logic        new_pc_valid_o;
  logic [31:0] new_pc_o;
  logic        new_pc_ready_i;

  modport slave (
    input  mem_valid_i, mem_stall_i, mem_pc_i, mem_delayslot_i, mem_exc_i, mem_badvaddr_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    output excepttype_o, exc_pc_o, exc_badvaddr_o, exc_delayslot_o,
    output flush_o, busy_o,
    output new_pc_valid_o, new_pc_o,
    input  new_pc_ready_i
  );

  modport master (
    output mem_valid_i, mem_stall_i, mem_pc_i, mem_delayslot_i, mem_exc_i, mem_badvaddr_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  excepttype_o, exc_pc_o, exc_badvaddr_o, exc_delayslot_o,
    input  flush_o, busy_o,
    input  new_pc_valid_o, new_pc_o,
    output new_pc_ready_i
  );
endinterface

// File: rtl/exc_flush_ctrl.sv
// Exception/ERET sequencer: samples the retiring MEM instruction and pending
// interrupts, then commits one beat to CP0, flushes, and redirects fetch.
module exc_flush_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  exc_flush_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [31:0] CODE_INT  = 32'h01;
  localparam logic [31:0] CODE_ADEL = 32'h04;
  localparam logic [31:0] CODE_ADES = 32'h05;
  localparam logic [31:0] CODE_SYS  = 32'h08;
  localparam logic [31:0] CODE_BP   = 32'h09;
  localparam logic [31:0] CODE_RI   = 32'h0a;
  localparam logic [31:0] CODE_OV   = 32'h0c;
  localparam logic [31:0] CODE_TR   = 32'h0d;
  localparam logic [31:0] CODE_ERET = 32'h0e;

  // Flag positions inside mem_exc_i = {eret,tr,ov,ri,bp,sys,ades,adel}
  localparam int unsigned B_ADEL = 0;
  localparam int unsigned B_ADES = 1;
  localparam int unsigned B_SYS  = 2;
  localparam int unsigned B_BP   = 3;
  localparam int unsigned B_RI   = 4;
  localparam int unsigned B_OV   = 5;
  localparam int unsigned B_TR   = 6;
  localparam int unsigned B_ERET = 7;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    FLUSH,
    REDIRECT
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      target_q;

  logic             int_pending_c;
  logic             trigger_c;
  logic [31:0]      code_c;
  logic [31:0]      target_c;
  logic             unused_c;

  // Interrupt is pending when enabled, not at exception level, and any unmasked IP bit set
  assign int_pending_c = bus.cp0_status_i[0] & ~bus.cp0_status_i[1] &
                         (|(bus.cp0_cause_i[15:8] & bus.cp0_status_i[15:8]));

  assign trigger_c = bus.mem_valid_i & ~bus.mem_stall_i & (int_pending_c | (|bus.mem_exc_i));

  // Fixed-priority encode of the exception code; interrupt wins over every flag
  always_comb begin
    code_c = 32'h0;
    if (int_pending_c)                code_c = CODE_INT;
    else if (bus.mem_exc_i[B_ADEL])   code_c = CODE_ADEL;
    else if (bus.mem_exc_i[B_RI])     code_c = CODE_RI;
    else if (bus.mem_exc_i[B_OV])     code_c = CODE_OV;
    else if (bus.mem_exc_i[B_TR])     code_c = CODE_TR;
    else if (bus.mem_exc_i[B_SYS])    code_c = CODE_SYS;
    else if (bus.mem_exc_i[B_BP])     code_c = CODE_BP;
    else if (bus.mem_exc_i[B_ADES])   code_c = CODE_ADES;
    else if (bus.mem_exc_i[B_ERET])   code_c = CODE_ERET;
  end

  // ERET returns to the EPC as it stands before this commit updates CP0
  assign target_c = (code_c == CODE_ERET) ? bus.cp0_epc_i : EXC_VECTOR;

  // CP0 register bits this block does not look at
  assign unused_c = ^{bus.cp0_status_i[31:16], bus.cp0_status_i[7:2],
                      bus.cp0_cause_i[31:16], bus.cp0_cause_i[7:0]};

  // Sequencer with registered outputs, updated alongside each state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      target_q            <= 32'h0;
      bus.excepttype_o    <= 32'h0;
      bus.exc_pc_o        <= 32'h0;
      bus.exc_badvaddr_o  <= 32'h0;
      bus.exc_delayslot_o <= 1'b0;
      bus.flush_o         <= 1'b0;
      bus.busy_o          <= 1'b0;
      bus.new_pc_valid_o  <= 1'b0;
      bus.new_pc_o        <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_c) begin
            state_q             <= COMMIT;
            target_q            <= target_c;
            bus.excepttype_o    <= code_c;
            bus.exc_pc_o        <= bus.mem_pc_i;
            bus.exc_badvaddr_o  <= bus.mem_badvaddr_i;
            bus.exc_delayslot_o <= bus.mem_delayslot_i;
            bus.flush_o         <= 1'b1;
            bus.busy_o          <= 1'b1;
          end
        end
        COMMIT: begin
          state_q             <= FLUSH;
          cnt_q               <= CNT_LOAD;
          bus.excepttype_o    <= 32'h0;
          bus.exc_pc_o        <= 32'h0;
          bus.exc_badvaddr_o  <= 32'h0;
          bus.exc_delayslot_o <= 1'b0;
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_q            <= REDIRECT;
            bus.flush_o        <= 1'b0;
            bus.new_pc_valid_o <= 1'b1;
            bus.new_pc_o       <= target_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        REDIRECT: begin
          if (bus.new_pc_ready_i) begin
            state_q            <= IDLE;
            bus.new_pc_valid_o <= 1'b0;
            bus.new_pc_o       <= 32'h0;
            bus.busy_o         <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Bench for exc_flush_ctrl: directed scenarios plus random traffic, each cycle
// checked against a transaction-level model of the exception sequence.
module tb_exc_flush_ctrl;

  localparam int unsigned FC      = 2;
  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exc_flush_ctrl_if bus ();

  exc_flush_ctrl #(
    .EXC_VECTOR   (EXC_VEC),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Priority table, highest first: flag bit index and its code
  int unsigned pri_bit  [8] = '{0, 4, 5, 6, 2, 3, 1, 7};
  logic [31:0] pri_code [8] = '{32'h04, 32'h0a, 32'h0c, 32'h0d, 32'h08, 32'h09, 32'h05, 32'h0e};

  // Model: cycles elapsed since the trigger, plus the latched transaction
  bit          m_active = 1'b0;
  int          m_k      = 0;
  logic [31:0] m_code, m_pc, m_bva, m_tgt;
  logic        m_ds;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit irq(input logic [31:0] st, input logic [31:0] ca);
    return st[0] && !st[1] && ((st[15:8] & ca[15:8]) != 8'h0);
  endfunction

  function automatic logic [31:0] exp_code(input logic [31:0] st, input logic [31:0] ca,
                                           input logic [7:0] ex);
    if (irq(st, ca)) return 32'h01;
    for (int i = 0; i < 8; i++)
      if (ex[pri_bit[i]]) return pri_code[i];
    return 32'h0;
  endfunction

  // Advance one clock: update the model from the inputs of the cycle just ended, then check
  task automatic step();
    logic        s_rst   = rst;
    logic        s_valid = bus.mem_valid_i;
    logic        s_stall = bus.mem_stall_i;
    logic [31:0] s_pc    = bus.mem_pc_i;
    logic        s_ds    = bus.mem_delayslot_i;
    logic [7:0]  s_exc   = bus.mem_exc_i;
    logic [31:0] s_bva   = bus.mem_badvaddr_i;
    logic [31:0] s_st    = bus.cp0_status_i;
    logic [31:0] s_ca    = bus.cp0_cause_i;
    logic [31:0] s_epc   = bus.cp0_epc_i;
    logic        s_rdy   = bus.new_pc_ready_i;
    bit commit, redir;
    @(posedge clk);
    if (s_rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (s_valid && !s_stall && (irq(s_st, s_ca) || s_exc != 8'h0)) begin
        m_active = 1'b1;
        m_k      = 1;
        m_code   = exp_code(s_st, s_ca, s_exc);
        m_pc     = s_pc;
        m_bva    = s_bva;
        m_ds     = s_ds;
        m_tgt    = (m_code == 32'h0e) ? s_epc : EXC_VEC;
      end
    end else if (m_k >= 2 + FC && s_rdy) begin
      m_active = 1'b0;
    end else if (m_k < 100000) begin
      m_k++;
    end
    #1;
    commit = m_active && m_k == 1;
    redir  = m_active && m_k >= 2 + FC;
    chk("excepttype", bus.excepttype_o, commit ? m_code : 32'h0);
    chk("exc_pc", bus.exc_pc_o, commit ? m_pc : 32'h0);
    chk("exc_badvaddr", bus.exc_badvaddr_o, commit ? m_bva : 32'h0);
    chk("exc_delayslot", 32'(bus.exc_delayslot_o), 32'(commit && m_ds));
    chk("flush", 32'(bus.flush_o), 32'(m_active && m_k <= 1 + FC));
    chk("busy", 32'(bus.busy_o), 32'(m_active));
    chk("new_pc_valid", 32'(bus.new_pc_valid_o), 32'(redir));
    chk("new_pc", bus.new_pc_o, redir ? m_tgt : 32'h0);
  endtask

  task automatic quiet();
    bus.mem_valid_i     = 1'b0;
    bus.mem_stall_i     = 1'b0;
    bus.mem_exc_i       = 8'h0;
    bus.mem_delayslot_i = 1'b0;
  endtask

  task automatic present(input logic [31:0] pc, input logic [7:0] ex,
                         input logic ds, input logic [31:0] bva);
    bus.mem_valid_i     = 1'b1;
    bus.mem_stall_i     = 1'b0;
    bus.mem_pc_i        = pc;
    bus.mem_exc_i       = ex;
    bus.mem_delayslot_i = ds;
    bus.mem_badvaddr_i  = bva;
  endtask

  int          cnt;
  logic [31:0] held_pc;

  initial begin
    quiet();
    bus.mem_pc_i       = 32'h0;
    bus.mem_badvaddr_i = 32'h0;
    bus.cp0_status_i   = 32'h0;
    bus.cp0_cause_i    = 32'h0;
    bus.cp0_epc_i      = 32'h0;
    bus.new_pc_ready_i = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // 1: sys at 0xBFC00100, redirect to the vector
    present(32'hBFC00100, 8'h04, 1'b0, 32'h0);
    step();
    quiet();
    chk("t1_code", bus.excepttype_o, 32'h08);
    chk("t1_pc", bus.exc_pc_o, 32'hBFC00100);
    step(); step(); step();
    chk("t1_target", bus.new_pc_o, EXC_VEC);
    chk("t1_valid", 32'(bus.new_pc_valid_o), 32'h1);
    bus.new_pc_ready_i = 1'b1;
    step();
    bus.new_pc_ready_i = 1'b0;
    step();

    // 2: eret with ready tied high, target is the pre-commit EPC
    bus.cp0_epc_i      = 32'h80001234;
    bus.new_pc_ready_i = 1'b1;
    present(32'h80000040, 8'h80, 1'b0, 32'h0);
    step();
    quiet();
    chk("t2_code", bus.excepttype_o, 32'h0e);
    bus.cp0_epc_i = 32'h80000040;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.new_pc_valid_o && bus.new_pc_o == 32'h80001234) cnt++;
    end
    chk("t2_valid_cycles", 32'(cnt), 32'h1);
    chk("t2_idle", 32'(bus.busy_o), 32'h0);

    // 3: interrupt beats ov; with EXL set ov is taken instead
    bus.cp0_status_i = 32'h0000FF01;
    bus.cp0_cause_i  = 32'h00008000;
    present(32'h80000100, 8'h20, 1'b0, 32'h0);
    step();
    quiet();
    chk("t3_int", bus.excepttype_o, 32'h01);
    for (int i = 0; i < 6; i++) step();
    bus.cp0_status_i = 32'h0000FF03;
    present(32'h80000104, 8'h20, 1'b0, 32'h0);
    step();
    quiet();
    chk("t3_exl_ov", bus.excepttype_o, 32'h0c);
    for (int i = 0; i < 6; i++) step();
    bus.cp0_status_i = 32'h0;
    bus.cp0_cause_i  = 32'h0;

    // 4: adel and ades together in a delay slot
    present(32'h80000200, 8'h03, 1'b1, 32'h00000003);
    step();
    quiet();
    chk("t4_code", bus.excepttype_o, 32'h04);
    chk("t4_bva", bus.exc_badvaddr_o, 32'h3);
    chk("t4_ds", 32'(bus.exc_delayslot_o), 32'h1);
    for (int i = 0; i < 6; i++) step();

    // 5: fetch stalls the redirect while new flags keep arriving
    bus.new_pc_ready_i = 1'b0;
    present(32'h80000300, 8'h08, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 1 + FC; i++) step();
    held_pc = bus.new_pc_o;
    cnt = 0;
    present(32'h80000400, 8'h10, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.excepttype_o != 32'h0) cnt++;
      chk("t5_stable", bus.new_pc_o, held_pc);
    end
    chk("t5_no_commit", 32'(cnt), 32'h0);
    quiet();
    bus.new_pc_ready_i = 1'b1;
    step();
    bus.new_pc_ready_i = 1'b0;
    step();
    chk("t5_idle", 32'(bus.busy_o), 32'h0);

    // 6: reset in FLUSH aborts; stalled sys is ignored
    present(32'h80000500, 8'h04, 1'b0, 32'h0);
    step();
    quiet();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_flush", 32'(bus.flush_o), 32'h0);
    chk("t6_busy", 32'(bus.busy_o), 32'h0);
    present(32'h80000600, 8'h04, 1'b0, 32'h0);
    bus.mem_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_stall", bus.excepttype_o, 32'h0);
    end
    quiet();
    step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst                 = ($urandom_range(0, 199) == 0);
      bus.mem_valid_i     = ($urandom_range(0, 9) < 7);
      bus.mem_stall_i     = ($urandom_range(0, 9) < 2);
      bus.mem_pc_i        = $urandom;
      bus.mem_delayslot_i = 1'($urandom);
      bus.mem_exc_i       = 8'($urandom & $urandom & $urandom);
      bus.mem_badvaddr_i  = $urandom;
      bus.cp0_status_i    = $urandom & 32'h0000FF03;
      bus.cp0_cause_i     = ($urandom & $urandom) & 32'h0000FF00;
      bus.cp0_epc_i       = $urandom;
      bus.new_pc_ready_i  = 1'($urandom);
      step();
    end
    rst = 1'b0;
    quiet();
    bus.new_pc_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
